// File: rtl/serialsubtractor_fsm.sv
// serialsubtractor_fsm
// Bit-serial unsigned subtractor. The result is computed LSB first, one difference bit per
// SHIFT cycle.
//   clk   : rising-edge clock for all state
//   rst_n : synchronous active-low reset
//   start : request a subtraction; only sampled while ready=1
//   a, b  : minuend / subtrahend, captured on the accepted start edge
//   ready : high in IDLE
//   busy  : high in SHIFT
//   done  : one-cycle pulse; diff and bout are valid
//   diff  : (a - b) mod 2^WIDTH; holds until the next accepted start
//   bout  : final borrow, 1 iff a < b
module serialsubtractor_fsm #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             br_q, br_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             d_bit;
   logic             br_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      d_bit   = a_q[0] ^ b_q[0] ^ br_q;
      br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      br_d    = br_q;
      cnt_d   = cnt_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StShift;
               a_d     = a;
               b_d     = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               diff_d  = '0;
               bout_d  = 1'b0;
            end
         end
         StShift: begin
            // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
            diff_d = {d_bit, diff_q[WIDTH-1:1]};
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = br_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
               state_d = StDone;
               bout_d  = br_next;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ready = (state_q == StIdle);
   assign busy  = (state_q == StShift);
   assign done  = (state_q == StDone);
   assign diff  = diff_q;
   assign bout  = bout_q;

endmodule

// File: tb/tb_serialsubtractor_fsm.sv
// Self-checking bench for serialsubtractor_fsm (WIDTH=8): a transaction-level model
// (countdown + plain arithmetic) checked every cycle, plus literal-value directed cases.
module tb_serialsubtractor_fsm;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ready, busy, done, bout;
   logic [W-1:0] diff;

   serialsubtractor_fsm #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_done = 0;
   bit last_rand = 1'b0;
   bit rand_mode = 1'b0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (time %0t)", name, got, want, $time);
      end
   endtask

   // Model: m_timer counts cycles until the block is idle again.
   // W+1..2 = shifting, 1 = done cycle, 0 = idle.
   int           m_timer = 0;
   logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
   logic         m_bout = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_timer <= 0;
         m_diff  <= '0;
         m_bout  <= 1'b0;
      end else if (m_timer == 0) begin
         if (start) begin
            m_timer <= W + 1;
            m_a     <= a;
            m_b     <= b;
            m_diff  <= '0;
            m_bout  <= 1'b0;
         end
      end else begin
         m_timer <= m_timer - 1;
         if (m_timer == 2) begin
            m_diff <= m_a - m_b;
            m_bout <= (m_a < m_b);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cyc++;
         check("ready", {31'b0, ready}, {31'b0, m_timer == 0});
         check("busy", {31'b0, busy}, {31'b0, m_timer > 1});
         check("done", {31'b0, done}, {31'b0, m_timer == 1});
         if (m_timer <= 1) begin
            check("diff", {24'b0, diff}, {24'b0, m_diff});
            check("bout", {31'b0, bout}, {31'b0, m_bout});
         end
         if (done) begin
            done_cnt++;
            if (rand_mode && last_rand) check("done_period", cyc - last_done, W + 2);
            last_done = cyc;
            last_rand = rand_mode;
         end
      end
   end

   // One operation with literal expectations; checks latency and ready return.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] ed, input logic eb, input string name);
      int n;
      @(posedge clk); #1;
      check({name, "_ready_before"}, {31'b0, ready}, 32'd1);
      start = 1'b1; a = ta; b = tb_v;
      @(posedge clk); #1;  // edge 0
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      n = 0;
      while (!done && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, n, W);
      check({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
      check({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
      @(posedge clk); #1;
      check({name, "_ready_after"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      int d0, n;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("reset_ready", {31'b0, ready}, 32'd1);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_diff", {24'b0, diff}, 32'd0);
      check("reset_bout", {31'b0, bout}, 32'd0);
      rst_n = 1'b1;

      run_op(8'h05, 8'h03, 8'h02, 1'b0, "basic");
      run_op(8'h03, 8'h05, 8'hFE, 1'b1, "neg1");
      run_op(8'h00, 8'hFF, 8'h01, 1'b1, "neg2");
      run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "ones");
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, "msb");

      // start and operand changes during SHIFT must be ignored
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; a = 8'h10; b = 8'h01;
      @(posedge clk); #1;  // edge 0
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(posedge clk); #1;
      start = 1'b0; a = 8'hFF; b = 8'hFF;
      n = 0;
      while (!done && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_diff", {24'b0, diff}, 32'h0F);
      check("busy_bout", {31'b0, bout}, 32'd0);
      @(posedge clk); #1;
      check("busy_ready_after", {31'b0, ready}, 32'd1);
      check("busy_done_pulses", done_cnt - d0, 1);

      // reset in the middle of an operation aborts it silently
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; a = 8'h33; b = 8'h11;
      @(posedge clk); #1;  // edge 0
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;  // edge 4
      rst_n = 1'b1;
      check("midrst_diff", {24'b0, diff}, 32'd0);
      check("midrst_bout", {31'b0, bout}, 32'd0);
      check("midrst_ready", {31'b0, ready}, 32'd1);
      repeat (W + 2) begin
         @(posedge clk); #1;
      end
      check("midrst_no_done", done_cnt - d0, 0);
      run_op(8'h33, 8'h11, 8'h22, 1'b0, "after_rst");

      // back-to-back random operations with start held high
      d0 = done_cnt;
      rand_mode = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 1000 * (W + 2) + 50 && (done_cnt - d0) < 1000; i++) begin
         @(posedge clk); #1;
         a = 8'($urandom);
         b = 8'($urandom);
      end
      start = 1'b0;
      rand_mode = 1'b0;
      repeat (W + 4) begin
         @(posedge clk); #1;
      end
      check("rand_done_count", done_cnt - d0, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
